// File: rtl/apb_master_mux.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_mux
// Brief    : APB4 master with per-slave select decode. Runs one APB transfer
//            per command taken on a valid/ready channel. Returns read data and
//            status on a valid/ready response channel. Status covers slave
//            error, access timeout and address decode error.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_mux #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // command channel
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    // response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_err,
    // APB fabric
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int c_sel_w = $clog2(NUM_SLV);
    localparam int c_cnt_w = $clog2(TIMEOUT + 1) + 1;

    localparam logic [c_sel_w:0]     c_num_slv = (c_sel_w + 1)'(NUM_SLV);
    localparam logic [c_cnt_w-1:0]   c_timeout = c_cnt_w'(TIMEOUT);
    localparam logic [NUM_SLV-1:0]   c_sel_one = NUM_SLV'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    localparam logic [1:0] c_err_ok     = 2'd0;
    localparam logic [1:0] c_err_slv    = 2'd1;
    localparam logic [1:0] c_err_tmo    = 2'd2;
    localparam logic [1:0] c_err_decode = 2'd3;

    logic [1:0]          r_state;
    logic [c_sel_w-1:0]  r_idx;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [c_sel_w-1:0]  w_cmd_idx;
    logic                w_cmd_hit;
    logic [NUM_SLV-1:0]  w_cmd_sel;
    logic                w_sel_ready;
    logic                w_sel_err;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_slv_rdata [NUM_SLV];

    // Slave index field of the incoming address; indices past NUM_SLV are unmapped.
    assign w_cmd_idx = cmd_addr[SLV_LSB +: c_sel_w];
    assign w_cmd_hit = ({1'b0, w_cmd_idx} < c_num_slv);
    assign w_cmd_sel = c_sel_one << w_cmd_idx;

    // Unpack the flat read-data bus into one word per slave.
    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rdata
            assign w_slv_rdata[gi] = prdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Only the addressed slave's handshake is observed; r_idx is always in range here.
    assign w_sel_ready = pready[r_idx];
    assign w_sel_err   = pslverr[r_idx];
    assign w_sel_rdata = w_slv_rdata[r_idx];

    // Counter value after this ACCESS cycle; abort when it reaches the limit.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == c_timeout);

    assign cmd_ready = (r_state == c_st_idle);

    // Transfer sequencer: command capture, APB phases, response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            r_cnt     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= c_err_ok;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                        pstrb  <= cmd_write ? cmd_strb : '0;
                        r_idx  <= w_cmd_idx;
                        if (w_cmd_hit) begin
                            psel    <= w_cmd_sel;
                            r_state <= c_st_setup;
                        end else begin
                            // Unmapped address: skip the bus entirely.
                            rsp_err   <= c_err_decode;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            r_state   <= c_st_resp;
                        end
                    end
                end
                c_st_setup: begin
                    penable <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= c_st_access;
                end
                c_st_access: begin
                    if (w_sel_ready) begin
                        // A ready in the last allowed cycle completes normally.
                        rsp_rdata <= (!pwrite && !w_sel_err) ? w_sel_rdata : '0;
                        rsp_err   <= w_sel_err ? c_err_slv : c_err_ok;
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= c_st_resp;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            rsp_err   <= c_err_tmo;
                            rsp_rdata <= '0;
                            psel      <= '0;
                            penable   <= 1'b0;
                            rsp_valid <= 1'b1;
                            r_state   <= c_st_resp;
                        end
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_mux
// Brief    : Directed self-checking bench for apb_master_mux. A 4-slave
//            instance covers normal, wait-state, slave-error, timeout,
//            back-pressure and reset cases; a 3-slave instance covers decode
//            error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_mux;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;

    // shared command/response stimulus
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_ready;

    // 4-slave instance
    logic              cmd_valid;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic [3:0]        psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;
    logic [4*DATA_W-1:0] prdata;
    logic [3:0]        pready;
    logic [3:0]        pslverr;

    // 3-slave instance
    logic              cmd_valid3;
    logic              cmd_ready3;
    logic              rsp_valid3;
    logic [DATA_W-1:0] rsp_rdata3;
    logic [1:0]        rsp_err3;
    logic [2:0]        psel3;
    logic              penable3;
    logic [ADDR_W-1:0] paddr3;
    logic              pwrite3;
    logic [DATA_W-1:0] pwdata3;
    logic [3:0]        pstrb3;
    logic [3*DATA_W-1:0] prdata3;
    logic [2:0]        pready3;
    logic [2:0]        pslverr3;

    int total;
    int bad;
    int pen_cnt;

    apb_master_mux #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(4), .SLV_LSB(12), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    apb_master_mux #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(3), .SLV_LSB(12), .TIMEOUT(16)
    ) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
        .rsp_err(rsp_err3),
        .psel(psel3), .penable(penable3), .paddr(paddr3), .pwrite(pwrite3),
        .pwdata(pwdata3), .pstrb(pstrb3), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command; returns in the cycle after the accept edge.
    task automatic issue(input logic use3, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        if (use3) begin
            cmd_valid3 = 1'b1;
            chk("accept cmd_ready3", cmd_ready3, 1);
        end else begin
            cmd_valid = 1'b1;
            chk("accept cmd_ready", cmd_ready, 1);
        end
        step();
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
    endtask

    // Complete the response handshake on the 4-slave instance.
    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post rsp_valid", rsp_valid, 0);
        chk("post cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_strb   = '0;
        rsp_ready  = 1'b0;
        prdata     = '0;
        pready     = '0;
        pslverr    = '0;
        prdata3    = '0;
        pready3    = 3'b111;
        pslverr3   = '0;

        // ---- reset state
        step();
        step();
        chk("rst psel", psel, 0);
        chk("rst penable", penable, 0);
        chk("rst paddr", paddr, 0);
        chk("rst pwdata", pwdata, 0);
        chk("rst pstrb", pstrb, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_err", rsp_err, 0);
        rst = 1'b0;
        step();
        chk("rel cmd_ready", cmd_ready, 1);

        // ---- T1: zero-wait write to slave 1
        pready = 4'b1111;
        issue(0, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        chk("t1 setup psel", psel, 4'b0010);
        chk("t1 setup penable", penable, 0);
        chk("t1 paddr", paddr, 32'h0000_1004);
        chk("t1 pwrite", pwrite, 1);
        chk("t1 pwdata", pwdata, 32'hDEAD_BEEF);
        chk("t1 pstrb", pstrb, 4'hF);
        chk("t1 cmd_ready busy", cmd_ready, 0);
        chk("t1 setup rsp_valid", rsp_valid, 0);
        step();
        chk("t1 access psel", psel, 4'b0010);
        chk("t1 access penable", penable, 1);
        chk("t1 access rsp_valid", rsp_valid, 0);
        step();
        chk("t1 resp psel", psel, 0);
        chk("t1 resp penable", penable, 0);
        chk("t1 rsp_valid", rsp_valid, 1);
        chk("t1 rsp_err", rsp_err, 0);
        chk("t1 rsp_rdata", rsp_rdata, 0);
        finish_rsp();

        // ---- T2: read slave 2 with two wait states, slave 0 ready but ignored
        pready = 4'b0001;
        prdata = {32'hFFFF_0000, 32'h1234_5678, 32'h0F0F_0F0F, 32'hAAAA_5555};
        issue(0, 0, 32'h0000_2010, 32'h1111_2222, 4'hF);
        chk("t2 setup psel", psel, 4'b0100);
        chk("t2 pstrb", pstrb, 0);
        chk("t2 pwrite", pwrite, 0);
        step();
        chk("t2 acc1 penable", penable, 1);
        step();
        chk("t2 acc2 penable", penable, 1);
        chk("t2 acc2 rsp_valid", rsp_valid, 0);
        step();
        pready = 4'b0101;
        chk("t2 acc3 penable", penable, 1);
        chk("t2 acc3 pstrb", pstrb, 0);
        step();
        chk("t2 rsp_valid", rsp_valid, 1);
        chk("t2 rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("t2 rsp_err", rsp_err, 0);
        chk("t2 psel clr", psel, 0);
        finish_rsp();

        // ---- T3: slave error on slave 3
        pready  = 4'b1000;
        pslverr = 4'b1000;
        prdata  = {32'hCAFE_F00D, 96'h0};
        issue(0, 0, 32'h0000_3000, 32'h0, 4'h0);
        chk("t3 setup psel", psel, 4'b1000);
        step();
        chk("t3 access penable", penable, 1);
        step();
        chk("t3 psel clr", psel, 0);
        chk("t3 rsp_valid", rsp_valid, 1);
        chk("t3 rsp_err", rsp_err, 1);
        chk("t3 rsp_rdata", rsp_rdata, 0);
        finish_rsp();
        pslverr = '0;

        // ---- T4a: timeout, slave 0 never ready
        pready  = 4'b0000;
        prdata  = {96'h0, 32'h0BAD_F00D};
        issue(0, 0, 32'h0000_0000, 32'h0, 4'h0);
        pen_cnt = 0;
        for (int k = 0; k < 40 && !rsp_valid; k++) begin
            if (penable) pen_cnt++;
            step();
        end
        chk("t4a rsp_valid bound", rsp_valid, 1);
        chk("t4a penable cycles", pen_cnt, 16);
        chk("t4a rsp_err", rsp_err, 2);
        chk("t4a rsp_rdata", rsp_rdata, 0);
        chk("t4a psel clr", psel, 0);
        finish_rsp();

        // ---- T4b: ready arrives in the 16th ACCESS cycle
        issue(0, 0, 32'h0000_0000, 32'h0, 4'h0);
        for (int k = 2; k <= 17; k++) begin
            step();
            if (k == 17) pready = 4'b0001;
        end
        chk("t4b acc16 penable", penable, 1);
        chk("t4b acc16 psel", psel, 4'b0001);
        step();
        chk("t4b rsp_valid", rsp_valid, 1);
        chk("t4b rsp_err", rsp_err, 0);
        chk("t4b rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        finish_rsp();

        // ---- T5: decode error on the 3-slave instance
        issue(1, 0, 32'h0000_3000, 32'h0, 4'h0);
        chk("t5 psel3", psel3, 0);
        chk("t5 rsp_valid3", rsp_valid3, 1);
        chk("t5 rsp_err3", rsp_err3, 3);
        chk("t5 rsp_rdata3", rsp_rdata3, 0);
        chk("t5 cmd_ready3 busy", cmd_ready3, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t5 psel3 after", psel3, 0);
        chk("t5 rsp_valid3 after", rsp_valid3, 0);
        chk("t5 cmd_ready3 after", cmd_ready3, 1);

        // ---- T6: response back-pressure for 5 cycles
        pready = 4'b0010;
        prdata = {64'h0, 32'h55AA_33CC, 32'h0};
        issue(0, 0, 32'h0000_1008, 32'h0, 4'h0);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t6 hold rsp_valid", rsp_valid, 1);
            chk("t6 hold rsp_rdata", rsp_rdata, 32'h55AA_33CC);
            chk("t6 hold rsp_err", rsp_err, 0);
            chk("t6 hold cmd_ready", cmd_ready, 0);
            step();
        end
        finish_rsp();

        // ---- T7: asynchronous reset during ACCESS
        pready = 4'b0000;
        issue(0, 0, 32'h0000_2000, 32'h0, 4'h0);
        step();
        chk("t7 access penable", penable, 1);
        chk("t7 access psel", psel, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("t7 async psel", psel, 0);
        chk("t7 async penable", penable, 0);
        chk("t7 async rsp_valid", rsp_valid, 0);
        step();
        rst = 1'b0;
        chk("t7 rel cmd_ready", cmd_ready, 1);
        step();
        chk("t7 idle psel", psel, 0);
        chk("t7 idle rsp_valid", rsp_valid, 0);
        chk("t7 idle cmd_ready", cmd_ready, 1);

        // ---- T8: normal transfer after reset recovery
        pready = 4'b1111;
        issue(0, 1, 32'h0000_0040, 32'h0102_0304, 4'h3);
        chk("t8 setup psel", psel, 4'b0001);
        chk("t8 pstrb", pstrb, 4'h3);
        step();
        step();
        chk("t8 rsp_valid", rsp_valid, 1);
        chk("t8 rsp_err", rsp_err, 0);
        finish_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
